// File: rtl/alu_nibble_seq_if.sv
// Bundle of request, result and ALU-slice pins around the nibble sequencer.
// Both in_* and out_* use the same handshake: a transfer happens on a rising clk
// edge where valid && ready are both 1; the payload must be stable whenever valid is 1.
interface alu_nibble_seq_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;

    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_m;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;

    logic           alu_m1;
    logic           alu_m0;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic           alu_cin;
    logic [3:0]     alu_f;
    logic           alu_cout;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_res;
    logic           out_cout;
    logic           out_zero;

    // Environment side: requester, consumer and the combinational ALU slice.
    modport master (
        output in_valid, in_m, in_a, in_b, in_cin, out_ready, alu_f, alu_cout,
        input  in_ready, out_valid, out_res, out_cout, out_zero,
               alu_m1, alu_m0, alu_a, alu_b, alu_cin
    );

    modport slave (
        input  in_valid, in_m, in_a, in_b, in_cin, out_ready, alu_f, alu_cout,
        output in_ready, out_valid, out_res, out_cout, out_zero,
               alu_m1, alu_m0, alu_a, alu_b, alu_cin
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// Serial multi-nibble sequencer for a 4-bit ALU slice: one nibble per clock, LSB first,
// chain bit looped through a register. Optional zero flag: define ALU_SEQ_ZFLAG_EN.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_nibble_seq_if.slave bus,
    output logic [1:0]      dbg_state
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           c_q, c_d;
    logic [1:0]     m_q, m_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= 1'b0;
            m_q     <= 2'b00;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.in_m;
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    c_d     = bus.in_cin;
                    k_d     = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The chain bit is forwarded blindly; the ALU mode decides its meaning.
                res_d[{k_q, 2'b00} +: 4] = bus.alu_f;
                c_d                      = bus.alu_cout;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_res   = res_q;
        bus.out_cout  = c_q;
        bus.alu_m1    = m_q[1];
        bus.alu_m0    = m_q[0];
        bus.alu_a     = 4'h0;
        bus.alu_b     = 4'h0;
        bus.alu_cin   = 1'b0;
        // Operand pins are live only while a nibble is being computed.
        if (state_q == RUN) begin
            bus.alu_a   = a_q[{k_q, 2'b00} +: 4];
            bus.alu_b   = b_q[{k_q, 2'b00} +: 4];
            bus.alu_cin = c_q;
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    logic zero_q, zero_d;

    // Armed to 1 on accept, then knocked down by any non-zero result nibble.
    always_comb begin
        zero_d = zero_q;
        if (state_q == IDLE && bus.in_valid) begin
            zero_d = 1'b1;
        end else if (state_q == RUN) begin
            zero_d = zero_q & (bus.alu_f == 4'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.out_zero = zero_q;
`else
    assign bus.out_zero = 1'b0;
`endif

    assign dbg_state = state_q;
endmodule
